div_sqrt_prep_mvp: RTL

- Operand preparation stage directly upstream of the div/sqrt iteration control.
- Accepts a start pulse with raw IEEE operands in any of FP64/FP32/FP16/FP16alt.
- Unpacks operands, classifies them, and resolves special cases immediately.
- Normalizes denormal mantissas sequentially, then presents normalized sign/exponent/mantissa to the iteration stage over a valid/ready handshake.

---
 rtl/div_sqrt_prep_mvp_pkg.sv | 67 ++++++
 rtl/div_sqrt_unpack_mvp.sv | 64 ++++++
 rtl/div_sqrt_prep_mvp.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/div_sqrt_prep_mvp_pkg.sv
// Shared definitions for the div/sqrt operand preparation stage: format
// encodings, FSM states, internal widths and per-format IEEE constants.
package div_sqrt_prep_mvp_pkg;

    localparam int C_EXP_FP64     = 11;
    localparam int C_MANT_FP64    = 52;
    localparam int C_EXP_FP32     = 8;
    localparam int C_MANT_FP32    = 23;
    localparam int C_EXP_FP16     = 5;
    localparam int C_MANT_FP16    = 10;
    localparam int C_EXP_FP16ALT  = 8;
    localparam int C_MANT_FP16ALT = 7;

    // Internal mantissa carries the hidden bit; exponent is signed so that
    // denormal normalization can go below 1.
    localparam int C_MANT_W = C_MANT_FP64 + 1;
    localparam int C_EXP_W  = 13;

    localparam logic [63:0] C_QNAN_FP64    = 64'h7FF8_0000_0000_0000;
    localparam logic [31:0] C_QNAN_FP32    = 32'h7FC0_0000;
    localparam logic [15:0] C_QNAN_FP16    = 16'h7E00;
    localparam logic [15:0] C_QNAN_FP16ALT = 16'h7FC0;
    localparam logic [63:0] C_INF_FP64     = 64'h7FF0_0000_0000_0000;
    localparam logic [31:0] C_INF_FP32     = 32'h7F80_0000;
    localparam logic [15:0] C_INF_FP16     = 16'h7C00;
    localparam logic [15:0] C_INF_FP16ALT  = 16'h7F80;

    typedef enum logic [1:0] {
        FMT_FP32    = 2'b00,
        FMT_FP64    = 2'b01,
        FMT_FP16    = 2'b10,
        FMT_FP16ALT = 2'b11
    } fmt_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CLASSIFY = 2'd1,
        S_NORM     = 2'd2,
        S_HOLD     = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SPEC_ZERO = 2'd0,
        SPEC_INF  = 2'd1,
        SPEC_QNAN = 2'd2
    } spec_e;

    // Build a final special result in the selected format, zero-extended.
    // The generated QNaN is always positive.
    function automatic logic [63:0] special_value(input fmt_e fmt, input logic sign,
                                                  input spec_e kind);
        logic [63:0] v;
        v = '0;
        case (fmt)
            FMT_FP64: v = (kind == SPEC_QNAN) ? C_QNAN_FP64 :
                          (kind == SPEC_INF)  ? {sign, C_INF_FP64[62:0]} : {sign, 63'd0};
            FMT_FP32: v = {32'd0, (kind == SPEC_QNAN) ? C_QNAN_FP32 :
                          (kind == SPEC_INF)  ? {sign, C_INF_FP32[30:0]} : {sign, 31'd0}};
            FMT_FP16: v = {48'd0, (kind == SPEC_QNAN) ? C_QNAN_FP16 :
                          (kind == SPEC_INF)  ? {sign, C_INF_FP16[14:0]} : {sign, 15'd0}};
            default:  v = {48'd0, (kind == SPEC_QNAN) ? C_QNAN_FP16ALT :
                          (kind == SPEC_INF)  ? {sign, C_INF_FP16ALT[14:0]} : {sign, 15'd0}};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/div_sqrt_unpack_mvp.sv
// Combinational field extraction and classification of one raw operand.
// The fraction is left-justified into the FP64 fraction field so all
// formats share one internal mantissa layout.
module div_sqrt_unpack_mvp
    import div_sqrt_prep_mvp_pkg::*;
(
    input  logic [63:0]                i_operand,
    input  fmt_e                       i_fmt,
    output logic                       o_sign,
    output logic signed [C_EXP_W-1:0]  o_exp,
    output logic [C_MANT_W-1:0]        o_mant,
    output logic                       o_zero,
    output logic                       o_inf,
    output logic                       o_nan,
    output logic                       o_snan
);

    logic [C_EXP_FP64-1:0]  w_exp_field;
    logic                   w_exp_ones;
    logic [C_MANT_FP64-1:0] w_frac;
    logic                   w_exp_zero;
    logic                   w_frac_zero;

    // Select sign/exponent/fraction fields for the active format.
    always_comb begin
        o_sign      = i_operand[63];
        w_exp_field = i_operand[62:52];
        w_exp_ones  = &i_operand[62:52];
        w_frac      = i_operand[51:0];
        case (i_fmt)
            FMT_FP32: begin
                o_sign      = i_operand[31];
                w_exp_field = {3'd0, i_operand[30:23]};
                w_exp_ones  = &i_operand[30:23];
                w_frac      = {i_operand[22:0], 29'd0};
            end
            FMT_FP16: begin
                o_sign      = i_operand[15];
                w_exp_field = {6'd0, i_operand[14:10]};
                w_exp_ones  = &i_operand[14:10];
                w_frac      = {i_operand[9:0], 42'd0};
            end
            FMT_FP16ALT: begin
                o_sign      = i_operand[15];
                w_exp_field = {3'd0, i_operand[14:7]};
                w_exp_ones  = &i_operand[14:7];
                w_frac      = {i_operand[6:0], 45'd0};
            end
            default: ;
        endcase
    end

    assign w_exp_zero  = (w_exp_field == '0);
    assign w_frac_zero = (w_frac == '0);
    assign o_zero      = w_exp_zero & w_frac_zero;
    assign o_inf       = w_exp_ones & w_frac_zero;
    assign o_nan       = w_exp_ones & ~w_frac_zero;
    // Quiet bit is the fraction MSB, which left-justification puts at the top.
    assign o_snan      = o_nan & ~w_frac[C_MANT_FP64-1];
    // Denormals use exponent 1 with a cleared hidden bit.
    assign o_exp       = w_exp_zero ? 13'sd1 : $signed({2'b00, w_exp_field});
    assign o_mant      = {~w_exp_zero, w_frac};

endmodule

// File: rtl/div_sqrt_prep_mvp.sv
// Operand preparation ahead of the div/sqrt iteration: capture on start,
// classify and resolve special cases, normalize denormals one bit per cycle,
// then hold the prepared operands until the iteration stage takes them.
// Handshake: the result transfers on a cycle where Out_valid_SO and
// Out_ready_SI are both 1; while Out_valid_SO is 1 every output is stable.
module div_sqrt_prep_mvp
    import div_sqrt_prep_mvp_pkg::*;
#(
    parameter int MANT_W = C_MANT_W,
    parameter int EXP_W  = C_EXP_W
) (
    input  logic                    Clk_CI,
    input  logic                    Rst_RBI,
    input  logic                    Div_start_SI,
    input  logic                    Sqrt_start_SI,
    input  logic [63:0]             Operand_a_DI,
    input  logic [63:0]             Operand_b_DI,
    input  logic [2:0]              RM_SI,
    input  logic [1:0]              Format_sel_SI,
    input  logic                    Kill_SI,
    output logic                    Ready_SO,
    output logic                    Out_valid_SO,
    input  logic                    Out_ready_SI,
    output logic                    Div_op_SO,
    output logic                    Sign_a_DO,
    output logic                    Sign_b_DO,
    output logic signed [EXP_W-1:0] Exp_a_DO,
    output logic signed [EXP_W-1:0] Exp_b_DO,
    output logic [MANT_W-1:0]       Mant_a_DO,
    output logic [MANT_W-1:0]       Mant_b_DO,
    output logic [2:0]              RM_DO,
    output logic [1:0]              Format_sel_DO,
    output logic                    Special_SO,
    output logic [63:0]             Special_result_DO,
    output logic                    NV_SO,
    output logic                    DZ_SO,
    output logic [1:0]              o_dbg_state
);

    state_e                  r_state;
    logic                    r_ready, r_valid, r_div;
    logic [63:0]             r_op_a, r_op_b;
    logic [2:0]              r_rm;
    fmt_e                    r_fmt;
    logic                    r_sign_a, r_sign_b;
    logic signed [EXP_W-1:0] r_exp_a, r_exp_b;
    logic [MANT_W-1:0]       r_mant_a, r_mant_b;
    logic                    r_special, r_nv, r_dz;
    logic [63:0]             r_result;

    logic                    w_sign_a, w_sign_b;
    logic signed [EXP_W-1:0] w_exp_a, w_exp_b;
    logic [MANT_W-1:0]       w_mant_a, w_mant_b;
    logic                    w_zero_a, w_inf_a, w_nan_a, w_snan_a;
    logic                    w_zero_b, w_inf_b, w_nan_b, w_snan_b;
    logic                    w_special, w_res_sign, w_nv, w_dz;
    spec_e                   w_spec_kind;
    logic [MANT_W-1:0]       w_nrm_mant_a, w_nrm_mant_b;
    logic signed [EXP_W-1:0] w_nrm_exp_a, w_nrm_exp_b;
    logic                    w_cls_done, w_nrm_done;

    div_sqrt_unpack_mvp u_unpack_a (
        .i_operand (r_op_a), .i_fmt (r_fmt), .o_sign (w_sign_a), .o_exp (w_exp_a),
        .o_mant (w_mant_a), .o_zero (w_zero_a), .o_inf (w_inf_a), .o_nan (w_nan_a),
        .o_snan (w_snan_a)
    );

    div_sqrt_unpack_mvp u_unpack_b (
        .i_operand (r_op_b), .i_fmt (r_fmt), .o_sign (w_sign_b), .o_exp (w_exp_b),
        .o_mant (w_mant_b), .o_zero (w_zero_b), .o_inf (w_inf_b), .o_nan (w_nan_b),
        .o_snan (w_snan_b)
    );

    // Special-case decision, result sign and exception flags.
    always_comb begin
        w_special   = 1'b0;
        w_spec_kind = SPEC_ZERO;
        w_nv        = 1'b0;
        w_dz        = 1'b0;
        w_res_sign  = w_sign_a;
        if (r_div) begin
            w_res_sign = w_sign_a ^ w_sign_b;
            if (w_nan_a | w_nan_b) begin
                w_special = 1'b1; w_spec_kind = SPEC_QNAN; w_nv = w_snan_a | w_snan_b;
            end else if ((w_zero_a & w_zero_b) | (w_inf_a & w_inf_b)) begin
                w_special = 1'b1; w_spec_kind = SPEC_QNAN; w_nv = 1'b1;
            end else if (w_inf_a) begin
                w_special = 1'b1; w_spec_kind = SPEC_INF;
            end else if (w_zero_b) begin
                w_special = 1'b1; w_spec_kind = SPEC_INF; w_dz = 1'b1;
            end else if (w_zero_a | w_inf_b) begin
                w_special = 1'b1; w_spec_kind = SPEC_ZERO;
            end
        end else begin
            if (w_nan_a) begin
                w_special = 1'b1; w_spec_kind = SPEC_QNAN; w_nv = w_snan_a;
            end else if (w_zero_a) begin
                w_special = 1'b1; w_spec_kind = SPEC_ZERO;
            end else if (w_sign_a) begin
                w_special = 1'b1; w_spec_kind = SPEC_QNAN; w_nv = 1'b1;
            end else if (w_inf_a) begin
                w_special = 1'b1; w_spec_kind = SPEC_INF;
            end
        end
    end

    // One normalization step: shift only operands whose hidden bit is still 0.
    assign w_nrm_mant_a = r_mant_a[MANT_W-1] ? r_mant_a : {r_mant_a[MANT_W-2:0], 1'b0};
    assign w_nrm_mant_b = r_mant_b[MANT_W-1] ? r_mant_b : {r_mant_b[MANT_W-2:0], 1'b0};
    assign w_nrm_exp_a  = r_mant_a[MANT_W-1] ? r_exp_a : r_exp_a - EXP_W'(1);
    assign w_nrm_exp_b  = r_mant_b[MANT_W-1] ? r_exp_b : r_exp_b - EXP_W'(1);

    // Sqrt ignores B; the final shift and the move to HOLD share one edge.
    assign w_cls_done = w_mant_a[MANT_W-1] & (w_mant_b[MANT_W-1] | ~r_div);
    assign w_nrm_done = w_nrm_mant_a[MANT_W-1] & (w_nrm_mant_b[MANT_W-1] | ~r_div);

    // Control FSM and all registered outputs; Kill overrides everything.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_div     <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_rm      <= '0;
            r_fmt     <= FMT_FP32;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_exp_a   <= '0;
            r_exp_b   <= '0;
            r_mant_a  <= '0;
            r_mant_b  <= '0;
            r_special <= 1'b0;
            r_nv      <= 1'b0;
            r_dz      <= 1'b0;
            r_result  <= '0;
        end else if (Kill_SI) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Div_start_SI | Sqrt_start_SI) begin
                        r_op_a  <= Operand_a_DI;
                        r_op_b  <= Operand_b_DI;
                        r_rm    <= RM_SI;
                        r_fmt   <= fmt_e'(Format_sel_SI);
                        r_div   <= Div_start_SI;
                        r_ready <= 1'b0;
                        r_state <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    r_sign_a  <= w_sign_a;
                    r_sign_b  <= w_sign_b;
                    r_exp_a   <= w_exp_a;
                    r_exp_b   <= w_exp_b;
                    r_mant_a  <= w_mant_a;
                    r_mant_b  <= w_mant_b;
                    r_special <= w_special;
                    r_nv      <= w_nv;
                    r_dz      <= w_dz;
                    r_result  <= special_value(r_fmt, w_res_sign, w_spec_kind);
                    if (w_special | w_cls_done) begin
                        r_state <= S_HOLD;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_mant_a <= w_nrm_mant_a;
                    r_mant_b <= w_nrm_mant_b;
                    r_exp_a  <= w_nrm_exp_a;
                    r_exp_b  <= w_nrm_exp_b;
                    if (w_nrm_done) begin
                        r_state <= S_HOLD;
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    if (Out_ready_SI) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign Ready_SO          = r_ready;
    assign Out_valid_SO      = r_valid;
    assign Div_op_SO         = r_div;
    assign Sign_a_DO         = r_sign_a;
    assign Sign_b_DO         = r_sign_b;
    assign Exp_a_DO          = r_exp_a;
    assign Exp_b_DO          = r_exp_b;
    assign Mant_a_DO         = r_mant_a;
    assign Mant_b_DO         = r_mant_b;
    assign RM_DO             = r_rm;
    assign Format_sel_DO     = r_fmt;
    assign Special_SO        = r_special;
    assign Special_result_DO = r_result;
    assign NV_SO             = r_nv;
    assign DZ_SO             = r_dz;
    assign o_dbg_state       = r_state;

endmodule
